// File: rtl/count_sched_pkg.sv
// Shared types and helpers for the count_sched round-robin counter scheduler.
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_CW = 4;

  // Index of the set bit in a one-hot (up to 8 bits) vector; zero when no bit is set.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   winner_idx,
  output logic            valid
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   rotated;
  logic [IW-1:0]     offset;
  logic [IW:0]       sum;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    req_dbl = {req, req};
    rotated = NREQ'(req_dbl >> ptr);
    valid   = 1'b0;
    offset  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        valid  = 1'b1;
        offset = IW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    winner_idx = sum[IW-1:0];
    winner     = valid ? (NREQ'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters, each asking for a len+1 cycle slot.
import count_sched_pkg::*;

module count_sched #(
  parameter int NREQ = 4,
  parameter int CW   = DEF_CW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [CW-1:0]      cnt,
  output logic [NREQ-1:0]    done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [CW-1:0]   len_q, len_q_d;
  logic [CW-1:0]   cnt_d;
  logic [NREQ-1:0] grant_d, done_d;
  logic            busy_d;

  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic [CW-1:0]   win_len;
  logic [IW-1:0]   ptr_after_win;

  logic [7:0]      grant8, req8;
  logic [2:0]      owner;

  rr_arbiter #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .winner    (win),
    .winner_idx(win_idx),
    .valid     (win_valid)
  );

  // Owner index from the registered grant, plus the winner's length and the pointer just past it.
  always_comb begin
    grant8 = '0;
    grant8[NREQ-1:0] = grant;
    req8 = '0;
    req8[NREQ-1:0] = req;
    owner = onehot_to_idx(grant8);
    win_len = len[win_idx*CW +: CW];
    if (win_idx == IW'(NREQ - 1)) ptr_after_win = '0;
    else                          ptr_after_win = win_idx + IW'(1);
  end

  // Next-state and next-output logic; abort is checked before terminal count so it wins.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    len_q_d = len_q;
    cnt_d   = cnt;
    grant_d = grant;
    busy_d  = busy;
    done_d  = '0;
    case (state)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (win_valid) begin
          grant_d = win;
          busy_d  = 1'b1;
          len_q_d = win_len;
          ptr_d   = ptr_after_win;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req8[owner]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt == len_q) begin
          grant_d = '0;
          busy_d  = 1'b0;
          done_d  = grant;
          state_d = DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, latched length and all outputs are registered; reset drops everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      len_q <= '0;
      cnt   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      done  <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      len_q <= len_q_d;
      cnt   <= cnt_d;
      grant <= grant_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule
